// File: rtl/tlb_ctrl_if.sv
// tlb_ctrl_if: bundles every signal that tlb_ctrl exchanges with the IF stage,
// the MEM stage, CP0 and the tlb module.
//   slave  : tlb_ctrl side. It receives requests and TLB results and drives
//            the ready pulses, results, Random and the TLB control.
//   master : environment side (IF/MEM/CP0/tlb), the mirror image.
// Ports carried:
//   if_*  / mem_*           : lookup request, ready pulse and result per stage
//   wr_*                    : CP0 TLBWI/TLBWR write request and completion
//   cp0_wired, wired_we     : CP0 Wired value and its write strobe
//   random_o                : CP0 Random value
//   tlb_*                   : shared lookup/write port of the tlb module
interface tlb_ctrl_if #(
    parameter int INDEX_W = 4,
    parameter int DATA_W  = 64
);
    logic                if_req;
    logic [31:0]         if_addr;
    logic                if_rdy;
    logic [31:0]         if_paddr;
    logic [2:0]          if_exc;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_we;
    logic                mem_rdy;
    logic [31:0]         mem_paddr;
    logic [2:0]          mem_exc;
    logic                wr_req;
    logic                wr_random;
    logic [INDEX_W-1:0]  wr_index;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_done;
    logic [INDEX_W-1:0]  cp0_wired;
    logic                wired_we;
    logic [INDEX_W-1:0]  random_o;
    logic [31:0]         tlb_bus_addr;
    logic                tlb_bus_write;
    logic                tlb_ce;
    logic [31:0]         tlb_paddr_i;
    logic [2:0]          tlb_exc_i;
    logic                tlb_we;
    logic [INDEX_W-1:0]  tlb_index;
    logic [DATA_W-1:0]   tlb_data;

    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, mem_we,
        input  wr_req, wr_random, wr_index, wr_data,
        input  cp0_wired, wired_we, tlb_paddr_i, tlb_exc_i,
        output if_rdy, if_paddr, if_exc, mem_rdy, mem_paddr, mem_exc,
        output wr_done, random_o,
        output tlb_bus_addr, tlb_bus_write, tlb_ce, tlb_we, tlb_index, tlb_data
    );

    modport master (
        output if_req, if_addr, mem_req, mem_addr, mem_we,
        output wr_req, wr_random, wr_index, wr_data,
        output cp0_wired, wired_we, tlb_paddr_i, tlb_exc_i,
        input  if_rdy, if_paddr, if_exc, mem_rdy, mem_paddr, mem_exc,
        input  wr_done, random_o,
        input  tlb_bus_addr, tlb_bus_write, tlb_ce, tlb_we, tlb_index, tlb_data
    );
endinterface

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: shares the single TLB lookup/write port between instruction fetch,
// data memory and CP0 TLB writes, and owns the CP0 Random counter.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : tlb_ctrl_if.slave (requests, results, CP0 and TLB port signals)
// Operation: in IDLE a pending write wins, otherwise MEM is granted unless IF
// has waited through STARVE_MAX consecutive MEM grants. A lookup drives the
// TLB in the grant cycle, captures its combinational result at the edge and
// pulses rdy in RESP. A write drives tlb_we together with wr_done in WRITE.
module tlb_ctrl #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_W    = 4,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    tlb_ctrl_if.slave    bus
);
    localparam int                 STARVE_W  = $clog2(STARVE_MAX + 1);
    localparam logic [INDEX_W-1:0] TOP_INDEX = INDEX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  grant_if_s;
    logic                  grant_mem_s;
    logic                  take_wr_s;
    logic                  if_starved_s;
    logic [STARVE_W-1:0]   starve_cnt_r;
    logic [INDEX_W-1:0]    random_r;
    logic                  if_rdy_r;
    logic                  mem_rdy_r;
    logic [31:0]           if_paddr_r;
    logic [31:0]           mem_paddr_r;
    logic [2:0]            if_exc_r;
    logic [2:0]            mem_exc_r;
    logic                  wr_done_r;
    logic                  tlb_we_r;
    logic [INDEX_W-1:0]    wr_index_r;
    logic [DATA_W-1:0]     wr_data_r;

    assign if_starved_s = bus.if_req && (starve_cnt_r == STARVE_W'(STARVE_MAX));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: RESP and WRITE each last exactly one cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    state_next_s = ST_WRITE;
                end else if (bus.mem_req || bus.if_req) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESP:  state_next_s = ST_IDLE;
            ST_WRITE: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Grant decode for the IDLE cycle; held off while reset is active so the
    // TLB port is quiet during reset
    always_comb begin
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        take_wr_s   = 1'b0;
        if (rst && (state_r == ST_IDLE)) begin
            if (bus.wr_req) begin
                take_wr_s = 1'b1;
            end else if (bus.mem_req && !if_starved_s) begin
                grant_mem_s = 1'b1;
            end else if (bus.if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
            end
        end else begin
            take_wr_s = 1'b0;
        end
    end

    // The TLB lookup is combinational, so address and enable go out in the grant cycle
    assign bus.tlb_ce        = grant_if_s | grant_mem_s;
    assign bus.tlb_bus_write = grant_mem_s & bus.mem_we;
    assign bus.tlb_bus_addr  = grant_mem_s ? bus.mem_addr :
                               (grant_if_s ? bus.if_addr : 32'd0);

    // Result capture, ready/done pulses and latched write operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdy_r    <= 1'b0;
            mem_rdy_r   <= 1'b0;
            if_paddr_r  <= 32'd0;
            mem_paddr_r <= 32'd0;
            if_exc_r    <= 3'd0;
            mem_exc_r   <= 3'd0;
            wr_done_r   <= 1'b0;
            tlb_we_r    <= 1'b0;
            wr_index_r  <= '0;
            wr_data_r   <= '0;
        end else begin
            if_rdy_r  <= grant_if_s;
            mem_rdy_r <= grant_mem_s;
            wr_done_r <= take_wr_s;
            tlb_we_r  <= take_wr_s;
            if (grant_if_s) begin
                if_paddr_r <= bus.tlb_paddr_i;
                if_exc_r   <= bus.tlb_exc_i;
            end
            if (grant_mem_s) begin
                mem_paddr_r <= bus.tlb_paddr_i;
                mem_exc_r   <= bus.tlb_exc_i;
            end
            if (take_wr_s) begin
                // TLBWR samples Random in the cycle the write is accepted
                wr_index_r <= bus.wr_random ? random_r : bus.wr_index;
                wr_data_r  <= bus.wr_data;
            end
        end
    end

    // IF starvation counter: counts MEM wins while IF is waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= '0;
        end else if (grant_if_s) begin
            starve_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) && !bus.if_req) begin
            starve_cnt_r <= '0;
        end else if (grant_mem_s && (starve_cnt_r != STARVE_W'(STARVE_MAX))) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // CP0 Random: counts down to Wired then wraps to the top entry; the
    // wrap test also pins it at the top when Wired covers every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_r <= TOP_INDEX;
        end else if (bus.wired_we) begin
            random_r <= TOP_INDEX;
        end else if (random_r <= bus.cp0_wired) begin
            random_r <= TOP_INDEX;
        end else begin
            random_r <= random_r - INDEX_W'(1);
        end
    end

    assign bus.if_rdy    = if_rdy_r;
    assign bus.if_paddr  = if_paddr_r;
    assign bus.if_exc    = if_exc_r;
    assign bus.mem_rdy   = mem_rdy_r;
    assign bus.mem_paddr = mem_paddr_r;
    assign bus.mem_exc   = mem_exc_r;
    assign bus.wr_done   = wr_done_r;
    assign bus.tlb_we    = tlb_we_r;
    assign bus.tlb_index = wr_index_r;
    assign bus.tlb_data  = wr_data_r;
    assign bus.random_o  = random_r;
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: randomized requesters for IF, MEM and CP0 writes around
// tlb_ctrl, a stand-in TLB, a cycle-budget reference model that pushes the
// expected responses into queues, and a monitor that pops and compares them.
module tb_tlb_ctrl;
    localparam int STARVE_MAX = 4;

    typedef struct {
        int          due;
        logic [31:0] paddr;
        logic [2:0]  exc;
    } look_t;

    typedef struct {
        int          due;
        logic [3:0]  idx;
        logic [63:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   if_rate;
    int   mem_rate;
    int   wr_rate;
    logic wired_pulse_en;
    int   n_if_gnt;
    int   n_mem_gnt;
    int   n_wr_gnt;

    look_t ifq[$];
    look_t memq[$];
    wr_t   wq[$];

    int          free_at;
    int          starve;
    logic [3:0]  rnd_m;
    logic [31:0] last_if_pa;
    logic [31:0] last_mem_pa;
    logic [2:0]  last_if_exc;
    logic [2:0]  last_mem_exc;

    tlb_ctrl_if bus ();

    tlb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in TLB: translation keeps the low 29 bits, exception bits mix
    // address bits with the store flag; returns poison when not enabled
    function automatic logic [31:0] tlb_pa(input logic [31:0] va);
        return {3'b000, va[28:0]};
    endfunction

    function automatic logic [2:0] tlb_ex(input logic [31:0] va, input logic w);
        return va[5:3] ^ {2'b00, w};
    endfunction

    assign bus.tlb_paddr_i = bus.tlb_ce ? tlb_pa(bus.tlb_bus_addr) : 32'hDEAD_BEEF;
    assign bus.tlb_exc_i   = bus.tlb_ce ? tlb_ex(bus.tlb_bus_addr, bus.tlb_bus_write) : 3'b111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Random counter reference: down to Wired, then back to 15
    always @(posedge clk or negedge rst) begin
        if (!rst) rnd_m <= 4'd15;
        else if (bus.wired_we || (rnd_m <= bus.cp0_wired)) rnd_m <= 4'd15;
        else rnd_m <= rnd_m - 4'd1;
    end

    // Reference model: the port accepts one operation per two cycles;
    // the response appears in the cycle after acceptance
    always @(negedge clk) begin
        look_t lk;
        wr_t   wx;
        if (!rst) begin
            free_at = 0;
            starve  = 0;
        end else if (cyc >= free_at) begin
            if (bus.wr_req) begin
                wx.due  = cyc + 1;
                wx.idx  = bus.wr_random ? rnd_m : bus.wr_index;
                wx.data = bus.wr_data;
                wq.push_back(wx);
                free_at = cyc + 2;
                n_wr_gnt++;
            end else if (bus.mem_req || bus.if_req) begin
                if (bus.if_req && (!bus.mem_req || starve == STARVE_MAX)) begin
                    lk.due   = cyc + 1;
                    lk.paddr = tlb_pa(bus.if_addr);
                    lk.exc   = tlb_ex(bus.if_addr, 1'b0);
                    ifq.push_back(lk);
                    starve = 0;
                    n_if_gnt++;
                end else begin
                    lk.due   = cyc + 1;
                    lk.paddr = tlb_pa(bus.mem_addr);
                    lk.exc   = tlb_ex(bus.mem_addr, bus.mem_we);
                    memq.push_back(lk);
                    if (bus.if_req && starve < STARVE_MAX) starve = starve + 1;
                    n_mem_gnt++;
                end
                free_at = cyc + 2;
            end
            if (!bus.if_req) starve = 0;
        end
    end

    // Monitor: pops an expectation in the cycle it falls due and compares
    always @(negedge clk) begin
        logic exp_if;
        logic exp_mem;
        logic exp_wr;
        if (!rst) begin
            ifq.delete();
            memq.delete();
            wq.delete();
            last_if_pa = 32'd0; last_mem_pa = 32'd0;
            last_if_exc = 3'd0; last_mem_exc = 3'd0;
            chk("rst_rdy", 64'({bus.if_rdy, bus.mem_rdy, bus.wr_done, bus.tlb_we, bus.tlb_ce, bus.tlb_bus_write}), 64'd0);
            chk("rst_paddr", {bus.if_paddr, bus.mem_paddr}, 64'd0);
            chk("rst_exc", 64'({bus.if_exc, bus.mem_exc}), 64'd0);
            chk("rst_tlb_bus", 64'({bus.tlb_bus_addr, bus.tlb_index}), 64'd0);
            chk("rst_tlb_data", bus.tlb_data, 64'd0);
            chk("rst_random", 64'(bus.random_o), 64'd15);
        end else begin
            exp_if  = (ifq.size() > 0) && (ifq[0].due == cyc);
            exp_mem = (memq.size() > 0) && (memq[0].due == cyc);
            exp_wr  = (wq.size() > 0) && (wq[0].due == cyc);
            chk("if_rdy", 64'(bus.if_rdy), 64'(exp_if));
            chk("mem_rdy", 64'(bus.mem_rdy), 64'(exp_mem));
            chk("wr_done", 64'(bus.wr_done), 64'(exp_wr));
            chk("tlb_we", 64'(bus.tlb_we), 64'(exp_wr));
            if (exp_if) begin
                last_if_pa  = ifq[0].paddr;
                last_if_exc = ifq[0].exc;
                void'(ifq.pop_front());
            end
            if (exp_mem) begin
                last_mem_pa  = memq[0].paddr;
                last_mem_exc = memq[0].exc;
                void'(memq.pop_front());
            end
            // Results are checked in the rdy cycle and for holding afterwards
            chk("if_paddr", 64'(bus.if_paddr), 64'(last_if_pa));
            chk("if_exc", 64'(bus.if_exc), 64'(last_if_exc));
            chk("mem_paddr", 64'(bus.mem_paddr), 64'(last_mem_pa));
            chk("mem_exc", 64'(bus.mem_exc), 64'(last_mem_exc));
            if (exp_wr) begin
                chk("tlb_index", 64'(bus.tlb_index), 64'(wq[0].idx));
                chk("tlb_data", bus.tlb_data, wq[0].data);
                void'(wq.pop_front());
            end
            chk("random_o", 64'(bus.random_o), 64'(rnd_m));
        end
    end

    // IF requester: holds the request until if_rdy, then maybe issues another
    initial begin : if_drv
        logic done;
        forever begin
            @(negedge clk);
            done = bus.if_rdy;
            @(posedge clk);
            #1;
            if (done || !bus.if_req) begin
                if (int'($urandom_range(0, 99)) < if_rate) begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = $urandom;
                end else begin
                    bus.if_req = 1'b0;
                end
            end
        end
    end

    // MEM requester: same protocol, with a random load/store flag
    initial begin : mem_drv
        logic done;
        forever begin
            @(negedge clk);
            done = bus.mem_rdy;
            @(posedge clk);
            #1;
            if (done || !bus.mem_req) begin
                if (int'($urandom_range(0, 99)) < mem_rate) begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = $urandom;
                    bus.mem_we   = 1'($urandom_range(0, 1));
                end else begin
                    bus.mem_req = 1'b0;
                end
            end
        end
    end

    // CP0 write requester: TLBWI or TLBWR, held until wr_done
    initial begin : wr_drv
        logic done;
        forever begin
            @(negedge clk);
            done = bus.wr_done;
            @(posedge clk);
            #1;
            if (done || !bus.wr_req) begin
                if (int'($urandom_range(0, 99)) < wr_rate) begin
                    bus.wr_req    = 1'b1;
                    bus.wr_random = 1'($urandom_range(0, 1));
                    bus.wr_index  = 4'($urandom_range(0, 15));
                    bus.wr_data   = {$urandom, $urandom};
                end else begin
                    bus.wr_req = 1'b0;
                end
            end
        end
    end

    // Occasional CP0 Wired write strobes
    initial begin : wired_drv
        forever begin
            @(posedge clk);
            #1;
            bus.wired_we = wired_pulse_en && ($urandom_range(0, 15) == 0);
        end
    end

    initial begin
        rst = 1'b0;
        n_cmp = 0; n_bad = 0;
        n_if_gnt = 0; n_mem_gnt = 0; n_wr_gnt = 0;
        if_rate = 0; mem_rate = 0; wr_rate = 0;
        wired_pulse_en = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.mem_req = 1'b0; bus.mem_addr = 32'd0; bus.mem_we = 1'b0;
        bus.wr_req = 1'b0; bus.wr_random = 1'b0; bus.wr_index = 4'd0; bus.wr_data = 64'd0;
        bus.cp0_wired = 4'd3; bus.wired_we = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;

        // Mixed random traffic with Wired = 3
        if_rate = 60; mem_rate = 60; wr_rate = 10;
        repeat (600) @(posedge clk);

        // Both lookups held continuously: IF must win after four MEM grants
        #1 if_rate = 100; mem_rate = 100; wr_rate = 0;
        repeat (120) @(posedge clk);

        // Wired changes and strobes with writes mixed in
        #1 if_rate = 50; mem_rate = 50; wr_rate = 20;
        wired_pulse_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.cp0_wired = 4'($urandom_range(0, 15));
            repeat (50) @(posedge clk);
            #1;
        end
        wired_pulse_en = 1'b0;

        // Wired covering every entry keeps Random at 15
        bus.cp0_wired = 4'd15;
        repeat (100) @(posedge clk);
        #1 bus.cp0_wired = 4'd0;

        // Reset while a MEM lookup is in its response cycle
        mem_rate = 100; wr_rate = 0;
        for (int k = 0; k < 60 && !bus.mem_rdy; k++) begin
            @(posedge clk);
            #1;
        end
        chk("resp_reached", 64'(bus.mem_rdy), 64'd1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        if_rate = 50; mem_rate = 70; wr_rate = 15;
        repeat (300) @(posedge clk);

        // Drain and confirm every accepted operation completed
        #1 if_rate = 0; mem_rate = 0; wr_rate = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("ifq_drained", 64'(ifq.size()), 64'd0);
        chk("memq_drained", 64'(memq.size()), 64'd0);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("if_grants_seen", 64'(n_if_gnt > 50), 64'd1);
        chk("mem_grants_seen", 64'(n_mem_gnt > 50), 64'd1);
        chk("wr_grants_seen", 64'(n_wr_gnt > 10), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
